lsu_mem_arbiter: RTL



---
 rtl/lsu_mem_arbiter_pkg.sv | 13 +
 rtl/lsu_mem_arbiter_rr_select.sv | 30 +++
 rtl/lsu_mem_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/lsu_mem_arbiter_pkg.sv
// lsu_mem_arbiter_pkg: shared FSM state type and sizing helper for the LSU memory arbiter
package lsu_mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        READ_WAITING  = 2'd1,
        WRITE_WAITING = 2'd2,
        RELAYING      = 2'd3
    } arb_state_t;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/lsu_mem_arbiter_rr_select.sv
// lsu_mem_arbiter_rr_select: rotating priority encoder, first requester at or after rr_ptr wins
module lsu_mem_arbiter_rr_select
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    localparam int IDX_BITS = idx_bits(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] req,
    input  logic [IDX_BITS-1:0]      rr_ptr,
    output logic                     found,
    output logic [IDX_BITS-1:0]      idx
);
    int sum;
    logic [IDX_BITS-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx = '0;
        sum = 0;
        cand = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            sum = int'(rr_ptr) + k;
            cand = IDX_BITS'(sum >= NUM_CONSUMERS ? sum - NUM_CONSUMERS : sum);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: round-robin share of one data-memory port among NUM_CONSUMERS LSUs, one transaction at a time
module lsu_mem_arbiter
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
    output logic                     mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address,
    input  logic                     mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data,
    output logic                     mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address,
    output logic [DATA_BITS-1:0]     mem_write_data,
    input  logic                     mem_write_ready
);
    localparam int IDX_BITS = idx_bits(NUM_CONSUMERS);

    arb_state_t state;
    logic [IDX_BITS-1:0] rr_ptr, grant_idx, sel_idx, next_ptr;
    logic [NUM_CONSUMERS-1:0] wv, req;
    logic found, rel_valid;

    assign wv = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
    assign req = consumer_read_valid | wv;
    assign next_ptr = (grant_idx == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0 : grant_idx + 1'b1;
    // the raised ready tells us which valid the granted consumer must drop
    assign rel_valid = consumer_read_ready[grant_idx] ? consumer_read_valid[grant_idx] : wv[grant_idx];

    lsu_mem_arbiter_rr_select #(.NUM_CONSUMERS(NUM_CONSUMERS)) u_rr_select (
        .req(req),
        .rr_ptr(rr_ptr),
        .found(found),
        .idx(sel_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant_idx <= '0;
            consumer_read_ready <= '0;
            consumer_write_ready <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) consumer_read_data[i] <= '0;
            mem_read_valid <= 1'b0;
            mem_read_address <= '0;
            mem_write_valid <= 1'b0;
            mem_write_address <= '0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant_idx <= sel_idx;
                    if (consumer_read_valid[sel_idx]) begin
                        mem_read_valid <= 1'b1;
                        mem_read_address <= consumer_read_address[sel_idx];
                        state <= READ_WAITING;
                    end else begin
                        mem_write_valid <= 1'b1;
                        mem_write_address <= consumer_write_address[sel_idx];
                        mem_write_data <= consumer_write_data[sel_idx];
                        state <= WRITE_WAITING;
                    end
                end
                READ_WAITING: if (mem_read_ready) begin
                    mem_read_valid <= 1'b0;
                    consumer_read_data[grant_idx] <= mem_read_data;
                    consumer_read_ready[grant_idx] <= 1'b1;
                    state <= RELAYING;
                end
                WRITE_WAITING: if (mem_write_ready) begin
                    mem_write_valid <= 1'b0;
                    consumer_write_ready[grant_idx] <= 1'b1;
                    state <= RELAYING;
                end
                RELAYING: if (!rel_valid) begin
                    consumer_read_ready <= '0;
                    consumer_write_ready <= '0;
                    rr_ptr <= next_ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(mem_read_valid && mem_write_valid));
    assert property (@(posedge clk) disable iff (reset) $onehot0({consumer_read_ready, consumer_write_ready}));
endmodule
